// File: rtl/pwm_shadow_load_ctrl_if.sv
// Purpose : configuration/commit bundle between the register bank, the shadow loader and the carrier.
// Latency : n/a (signal bundle only).
// Backpressure: cfg_valid/cfg_ready handshake; the requester holds cfg_valid until cfg_ready.
// Ports   : master = register bank + carrier mask side (drives cfg_*, maskevent, force_load),
//           slave  = loader (drives cfg_ready, active_*, load_pulse, pending, clamp_flag, load_count).
interface pwm_shadow_load_ctrl_if #(
  parameter int CW   = 16,
  parameter int NCMP = 4,
  parameter int SKW  = 4
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CW-1:0]        cfg_period;
  logic [NCMP*CW-1:0]   cfg_compare;
  logic [SKW-1:0]       cfg_skip;
  logic                 maskevent;
  logic                 force_load;
  logic [CW-1:0]        active_period;
  logic [NCMP*CW-1:0]   active_compare;
  logic                 load_pulse;
  logic                 pending;
  logic                 clamp_flag;
  logic [7:0]           load_count;

  modport master (
    output cfg_valid, cfg_period, cfg_compare, cfg_skip, maskevent, force_load,
    input  cfg_ready, active_period, active_compare, load_pulse, pending, clamp_flag, load_count
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_compare, cfg_skip, maskevent, force_load,
    output cfg_ready, active_period, active_compare, load_pulse, pending, clamp_flag, load_count
  );
endinterface

// File: rtl/pwm_shadow_load_ctrl.sv
// Purpose : double-buffered PWM period/compare loader; shadow captured on handshake, committed
//           atomically to the active registers on a (skipped) mask event or a forced load.
// Latency : qualifying maskevent/force_load at edge k -> active values + load_pulse after edge k+1.
// Backpressure: cfg_ready is high only in IDLE; one configuration in flight at a time.
// Ports   : clk, reset (async, active-high), bus (slave modport of pwm_shadow_load_ctrl_if).
module pwm_shadow_load_ctrl #(
  parameter int            CW         = 16,
  parameter int            NCMP       = 4,
  parameter int            SKW        = 4,
  parameter logic [CW-1:0] PERIOD_RST = 16'd1000
) (
  input  logic                   clk,
  input  logic                   reset,
  pwm_shadow_load_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t               state;
  logic [CW-1:0]        shadow_period;
  logic [NCMP*CW-1:0]   shadow_compare;
  logic [SKW-1:0]       skip_cnt;

  logic [CW-1:0]        active_period;
  logic [NCMP*CW-1:0]   active_compare;
  logic                 load_pulse;
  logic                 pending;
  logic                 clamp_flag;
  logic [7:0]           load_count;

  logic                 ready;
  logic                 accept;
  logic [NCMP*CW-1:0]   clamped_compare;
  logic                 any_clamp;

  // Ready is combinational on the state so a requester sees it drop the instant reset asserts.
  assign ready  = (state == IDLE) & ~reset;
  assign accept = bus.cfg_valid & ready;

  // A compare beyond the period would never match the carrier; saturate it to the period
  // and remember (sticky) that software asked for something unreachable.
  always_comb begin
    clamped_compare = '0;
    any_clamp       = 1'b0;
    for (int i = 0; i < NCMP; i++) begin
      if (bus.cfg_compare[i*CW +: CW] > bus.cfg_period) begin
        clamped_compare[i*CW +: CW] = bus.cfg_period;
        any_clamp                   = 1'b1;
      end else begin
        clamped_compare[i*CW +: CW] = bus.cfg_compare[i*CW +: CW];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      shadow_period  <= '0;
      shadow_compare <= '0;
      skip_cnt       <= '0;
      active_period  <= PERIOD_RST;
      active_compare <= '0;
      load_pulse     <= 1'b0;
      pending        <= 1'b0;
      clamp_flag     <= 1'b0;
      load_count     <= 8'd0;
    end else begin
      load_pulse <= 1'b0;
      case (state)
        IDLE: begin
          // force_load and maskevent are meaningless without a pending shadow.
          if (accept) begin
            shadow_period  <= bus.cfg_period;
            shadow_compare <= clamped_compare;
            skip_cnt       <= bus.cfg_skip;
            if (any_clamp) begin
              clamp_flag <= 1'b1;
            end
            pending <= 1'b1;
            state   <= PEND;
          end
        end

        PEND: begin
          // force_load overrides the event path and leaves skip_cnt untouched.
          if (bus.force_load) begin
            state <= LOAD;
          end else if (bus.maskevent) begin
            if (skip_cnt == '0) begin
              state <= LOAD;
            end else begin
              skip_cnt <= skip_cnt - 1'b1;
            end
          end
        end

        LOAD: begin
          // Whole group commits in one edge so the carrier never sees a mixed configuration.
          active_period  <= shadow_period;
          active_compare <= shadow_compare;
          load_pulse     <= 1'b1;
          load_count     <= load_count + 8'd1;
          pending        <= 1'b0;
          state          <= IDLE;
        end

        default: begin
          pending <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.cfg_ready      = ready;
  assign bus.active_period  = active_period;
  assign bus.active_compare = active_compare;
  assign bus.load_pulse     = load_pulse;
  assign bus.pending        = pending;
  assign bus.clamp_flag     = clamp_flag;
  assign bus.load_count     = load_count;

endmodule

// File: tb/tb_pwm_shadow_load_ctrl.sv
// Purpose : self-checking bench for pwm_shadow_load_ctrl (vector table + hand sequences + commit scoreboard).
// Latency : n/a.
// Backpressure: requester side honours cfg_ready and holds cfg_valid until accepted.
module tb_pwm_shadow_load_ctrl;
  localparam int CW   = 16;
  localparam int NCMP = 4;
  localparam int SKW  = 4;
  localparam int NV   = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pwm_shadow_load_ctrl_if #(.CW(CW), .NCMP(NCMP), .SKW(SKW)) bus();

  pwm_shadow_load_ctrl #(
    .CW(CW), .NCMP(NCMP), .SKW(SKW), .PERIOD_RST(16'd1000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct packed {
    logic [CW-1:0]      period;
    logic [NCMP*CW-1:0] cmp;
    logic [7:0]         cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  typedef struct {
    logic [CW-1:0]      period;
    logic [NCMP*CW-1:0] cmp;
    logic [SKW-1:0]     skip;
    bit                 use_force;
    logic [NCMP*CW-1:0] exp_cmp;
    bit                 exp_clamp;
  } vec_t;

  vec_t vecs[NV];

  logic [7:0]         exp_count;
  logic [CW-1:0]      cur_period;
  logic [NCMP*CW-1:0] cur_cmp;

  function automatic logic [63:0] pack4(input logic [15:0] c0, input logic [15:0] c1,
                                        input logic [15:0] c2, input logic [15:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [CW-1:0] p, input logic [NCMP*CW-1:0] c);
    exp_count = exp_count + 8'd1;
    sb_q.push_back('{period: p, cmp: c, cnt: exp_count});
    cur_period = p;
    cur_cmp    = c;
  endtask

  task automatic offer(input logic [CW-1:0] p, input logic [NCMP*CW-1:0] c, input logic [SKW-1:0] s);
    bit done;
    done            = 1'b0;
    bus.cfg_period  = p;
    bus.cfg_compare = c;
    bus.cfg_skip    = s;
    bus.cfg_valid   = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      if (bus.cfg_ready) done = 1'b1;
      tick();
    end
    bus.cfg_valid = 1'b0;
    if (!done) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL offer_timeout: got cfg_ready=0 for 64 cycles, expected 1");
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    sb_q.delete();
    exp_count  = 8'd0;
    cur_period = 16'd1000;
    cur_cmp    = '0;
  endtask

  // Scoreboard: every load_pulse must match the oldest expected commit; active outputs
  // may only move together with load_pulse.
  logic [CW-1:0]      prev_period;
  logic [NCMP*CW-1:0] prev_cmp;
  logic               prev_reset = 1'b1;

  always @(negedge clk) begin
    if (!reset && bus.load_pulse) begin
      if (sb_q.size() == 0) begin
        err_cnt++;
        $display("FAIL unexpected_load_pulse: got load_pulse=1, expected 0 (period=%0d)", bus.active_period);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_period", 64'(bus.active_period), 64'(mon_e.period));
        check("sb_compare", bus.active_compare, mon_e.cmp);
        check("sb_load_count", 64'(bus.load_count), 64'(mon_e.cnt));
      end
    end else if (!reset && !prev_reset &&
                 (bus.active_period !== prev_period || bus.active_compare !== prev_cmp)) begin
      err_cnt++;
      $display("FAIL active_change_without_pulse: got period=%0d, expected %0d", bus.active_period, prev_period);
    end
    prev_period = bus.active_period;
    prev_cmp    = bus.active_compare;
    prev_reset  = reset;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'd800,   pack4(10, 20, 30, 40),          4'd2,  1'b0, pack4(10, 20, 30, 40),          1'b0};
    vecs[1] = '{16'd500,   pack4(600, 1, 2, 3),            4'd0,  1'b0, pack4(500, 1, 2, 3),            1'b1};
    vecs[2] = '{16'd900,   pack4(5, 6, 7, 8),              4'd1,  1'b0, pack4(5, 6, 7, 8),              1'b1};
    vecs[3] = '{16'd0,     pack4(0, 0, 0, 0),              4'd0,  1'b1, pack4(0, 0, 0, 0),              1'b1};
    vecs[4] = '{16'd65535, pack4(65535, 0, 1, 65534),      4'd15, 1'b0, pack4(65535, 0, 1, 65534),      1'b1};
    vecs[5] = '{16'd0,     pack4(1, 0, 9, 0),              4'd0,  1'b0, pack4(0, 0, 0, 0),              1'b1};

    bus.cfg_valid   = 1'b0;
    bus.cfg_period  = '0;
    bus.cfg_compare = '0;
    bus.cfg_skip    = '0;
    bus.maskevent   = 1'b0;
    bus.force_load  = 1'b0;
    apply_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("ready_in_reset", 64'(bus.cfg_ready), 64'd0);
    check("rst_period", 64'(bus.active_period), 64'd1000);
    reset = 1'b0;
    tick();
    check("ready_after_reset", 64'(bus.cfg_ready), 64'd1);
    check("rst_compare", bus.active_compare, 64'd0);
    check("rst_load_count", 64'(bus.load_count), 64'd0);
    check("rst_pending", 64'(bus.pending), 64'd0);
    check("rst_clamp", 64'(bus.clamp_flag), 64'd0);

    // Basic commit with exact latency
    offer(16'd500, pack4(100, 200, 300, 400), 4'd0);
    repeat (5) tick();
    check("pend_before_event", 64'(bus.pending), 64'd1);
    check("hold_period", 64'(bus.active_period), 64'd1000);
    bus.maskevent = 1'b1;
    push_exp(16'd500, pack4(100, 200, 300, 400));
    tick();
    bus.maskevent = 1'b0;
    check("no_pulse_in_load", 64'(bus.load_pulse), 64'd0);
    check("hold_in_load", 64'(bus.active_period), 64'd1000);
    tick();
    check("pulse_at_commit", 64'(bus.load_pulse), 64'd1);
    check("commit_period", 64'(bus.active_period), 64'd500);
    check("commit_compare", bus.active_compare, pack4(100, 200, 300, 400));
    check("ready_at_commit", 64'(bus.cfg_ready), 64'd1);
    check("count_1", 64'(bus.load_count), 64'd1);
    tick();
    check("pulse_one_cycle", 64'(bus.load_pulse), 64'd0);

    // maskevent already high at acceptance: commit 2 edges after the handshake
    bus.maskevent = 1'b1;
    offer(16'd321, pack4(1, 2, 3, 4), 4'd0);
    push_exp(16'd321, pack4(1, 2, 3, 4));
    tick();
    check("early_no_pulse", 64'(bus.load_pulse), 64'd0);
    tick();
    bus.maskevent = 1'b0;
    check("early_pulse", 64'(bus.load_pulse), 64'd1);
    tick();

    // Vector table
    for (int v = 0; v < NV; v++) begin
      offer(vecs[v].period, vecs[v].cmp, vecs[v].skip);
      if (vecs[v].use_force) begin
        push_exp(vecs[v].period, vecs[v].exp_cmp);
        bus.force_load = 1'b1;
        tick();
        bus.force_load = 1'b0;
        tick();
      end else begin
        for (int k = 0; k <= int'(vecs[v].skip); k++) begin
          if (k == int'(vecs[v].skip)) push_exp(vecs[v].period, vecs[v].exp_cmp);
          bus.maskevent = 1'b1;
          tick();
          bus.maskevent = 1'b0;
          tick();
          if (k < int'(vecs[v].skip) && k < 2) begin
            check($sformatf("v%0d_skip_hold_pending", v), 64'(bus.pending), 64'd1);
          end
        end
      end
      check($sformatf("v%0d_pending", v), 64'(bus.pending), 64'd0);
      check($sformatf("v%0d_period", v), 64'(bus.active_period), 64'(vecs[v].period));
      check($sformatf("v%0d_compare", v), bus.active_compare, vecs[v].exp_cmp);
      check($sformatf("v%0d_clamp", v), 64'(bus.clamp_flag), 64'(vecs[v].exp_clamp));
      check($sformatf("v%0d_count", v), 64'(bus.load_count), 64'(exp_count));
    end

    // force_load + maskevent together, and cfg_valid offered while pending
    offer(16'd300, pack4(1, 2, 3, 4), 4'd3);
    bus.cfg_period  = 16'd700;
    bus.cfg_compare = pack4(7, 7, 7, 7);
    bus.cfg_skip    = 4'd0;
    bus.cfg_valid   = 1'b1;
    tick();
    tick();
    check("ready_low_in_pend", 64'(bus.cfg_ready), 64'd0);
    bus.force_load = 1'b1;
    bus.maskevent  = 1'b1;
    push_exp(16'd300, pack4(1, 2, 3, 4));
    tick();
    bus.force_load = 1'b0;
    bus.maskevent  = 1'b0;
    tick();
    check("force_commit_period", 64'(bus.active_period), 64'd300);
    check("force_pulse", 64'(bus.load_pulse), 64'd1);
    tick();
    bus.cfg_valid = 1'b0;
    check("held_valid_accepted", 64'(bus.pending), 64'd1);
    bus.maskevent = 1'b1;
    push_exp(16'd700, pack4(7, 7, 7, 7));
    tick();
    bus.maskevent = 1'b0;
    tick();
    check("second_cfg_period", 64'(bus.active_period), 64'd700);

    // force_load in IDLE does nothing
    bus.force_load = 1'b1;
    tick();
    tick();
    bus.force_load = 1'b0;
    check("idle_force_pending", 64'(bus.pending), 64'd0);
    check("idle_force_count", 64'(bus.load_count), 64'(exp_count));

    // Reset while pending (skip=1, one event already consumed)
    offer(16'd222, pack4(2, 2, 2, 2), 4'd1);
    bus.maskevent = 1'b1;
    tick();
    bus.maskevent = 1'b0;
    apply_reset();
    #1;
    check("rst_pend_period", 64'(bus.active_period), 64'd1000);
    check("rst_pend_pending", 64'(bus.pending), 64'd0);
    check("rst_pend_clamp", 64'(bus.clamp_flag), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    bus.maskevent = 1'b1;
    tick();
    tick();
    bus.maskevent = 1'b0;
    tick();
    check("discarded_shadow", 64'(bus.active_period), 64'd1000);

    // Reset while in LOAD
    offer(16'd333, pack4(3, 3, 3, 3), 4'd0);
    bus.maskevent = 1'b1;
    tick();
    bus.maskevent = 1'b0;
    apply_reset();
    #1;
    check("rst_load_pulse", 64'(bus.load_pulse), 64'd0);
    check("rst_load_count", 64'(bus.load_count), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("rst_load_period", 64'(bus.active_period), 64'd1000);

    // 256 commits wrap the counter
    for (int i = 0; i < 256; i++) begin
      offer(16'(100 + i), pack4(16'(i), 16'(i), 16'(i), 16'(i)), 4'd0);
      push_exp(16'(100 + i), pack4(16'(i), 16'(i), 16'(i), 16'(i)));
      bus.force_load = 1'b1;
      tick();
      bus.force_load = 1'b0;
      tick();
    end
    check("count_wrap", 64'(bus.load_count), 64'd0);
    check("wrap_period", 64'(bus.active_period), 64'd355);
    check("no_clamp_yet", 64'(bus.clamp_flag), 64'd0);

    // period 0 with one nonzero compare sets the sticky clamp
    offer(16'd0, pack4(0, 0, 7, 0), 4'd0);
    push_exp(16'd0, 64'd0);
    bus.force_load = 1'b1;
    tick();
    bus.force_load = 1'b0;
    tick();
    check("zero_period_clamp", 64'(bus.clamp_flag), 64'd1);
    check("zero_period_compare", bus.active_compare, 64'd0);

    repeat (3) tick();
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/pwm_shadow_load_ctrl.md
Name: pwm_shadow_load_ctrl

Overview:
Double-buffered configuration loader for one PWM carrier/compare channel group.
- Accepts new period and compare values from the register interface through a valid/ready handshake.
- Holds them in shadow registers, then commits them atomically to the active registers on a carrier mask event (optionally after N skipped events) or on a forced load.
- Sits between the AXI register bank and the carrier counter/comparators; consumes the maskevent strobe produced by the carrier mask logic.

Parameters:
CW, 16, width of carrier period and compare values
NCMP, 4, number of compare channels sharing the same load event
SKW, 4, width of the mask-event skip counter
PERIOD_RST, 16'd1000, active_period value at reset

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cfg_valid  in  1  new configuration offered
cfg_ready  out  1  loader can accept a configuration
cfg_period  in  CW  requested carrier period
cfg_compare  in  NCMP*CW  requested compare values, channel i at bits [i*CW +: CW]
cfg_skip  in  SKW  number of mask events to skip before commit
maskevent  in  1  single-cycle-or-level mask event from carrier mask logic, sampled each clk
force_load  in  1  commit pending shadow immediately, ignoring maskevent/skip
active_period  out  CW  period currently driven to the carrier counter
active_compare  out  NCMP*CW  compare values currently driven to the comparators
load_pulse  out  1  one-cycle strobe, high in the cycle new active values first appear
pending  out  1  shadow holds an uncommitted configuration
clamp_flag  out  1  sticky: a captured compare exceeded its period and was clamped
load_count  out  8  number of commits since reset, wraps 255->0

Behaviour:
- Reset (async): state=IDLE, active_period=PERIOD_RST, active_compare=0, shadow regs=0, skip_cnt=0, load_pulse=0, pending=0, clamp_flag=0, load_count=0. cfg_ready=0 while reset is asserted.
- FSM states:
  - IDLE: cfg_ready=1, pending=0.
  - PEND: cfg_ready=0, pending=1.
  - LOAD: cfg_ready=0, pending=1, single cycle.
  - cfg_ready = (state==IDLE) & ~reset (combinational).
- IDLE -> PEND on cfg_valid & cfg_ready at edge k.
  - Capture shadow_period=cfg_period and skip_cnt=cfg_skip.
  - Capture each shadow_compare[i]=min(cfg_compare[i], cfg_period), unsigned compare.
  - If any channel is clamped, set clamp_flag=1 (cleared only by reset).
- PEND, evaluated per edge, priority order:
  - force_load=1 -> LOAD.
  - else maskevent=1 and skip_cnt==0 -> LOAD.
  - else maskevent=1 -> skip_cnt-1.
  - else hold.
  - A level-high maskevent counts once per cycle it is sampled high.
- LOAD -> IDLE at next edge:
  - active_period<=shadow_period, active_compare<=shadow_compare (all channels in the same edge, never partial).
  - load_pulse<=1 for exactly one cycle.
  - load_count<=load_count+1 (mod 256).
- Latency: qualifying maskevent sampled at edge k -> new active values and load_pulse visible after edge k+1. Handshake to earliest commit with cfg_skip=0 and maskevent already high = 2 edges after acceptance.
- cfg_valid while not IDLE: ignored, nothing captured; the requester holds cfg_valid until it sees cfg_ready.
- force_load in IDLE: no effect, no load_pulse.
- maskevent and force_load in the same PEND cycle: force_load wins; skip_cnt not decremented.
- cfg_skip = 2^SKW-1: commit on the 2^SKW-th mask event; no wrap of skip_cnt below 0.
- cfg_period=0: accepted; all compares clamp to 0. clamp_flag is set if any compare is nonzero.
- Reset mid-PEND or mid-LOAD: shadow is discarded, active values return to reset values, no load_pulse.
- Active outputs change only in the LOAD->IDLE transition.

Test Plan:
1. Reset, then read outputs -> active_period=1000, active_compare=0, cfg_ready=1 one cycle after reset deasserts, load_count=0.
2. Offer period=500, compares {100,200,300,400}, skip=0; pulse maskevent 5 cycles later -> active values update exactly 1 edge after the maskevent edge, load_pulse high 1 cycle, load_count=1, cfg_ready returns to 1 in the same cycle.
3. skip=2 with three single-cycle maskevents -> commit follows the third event only; no change after the first two.
4. Compare 600 with period 500 -> shadow/active compare=500, clamp_flag=1 and stays set across a later clean load.
5. In PEND, assert force_load and maskevent together with skip=3 -> immediate commit, load_pulse once. Offer a second cfg_valid during PEND -> not captured; it is accepted only after returning to IDLE.
6. Assert reset while in PEND with skip=1 -> active values back to 1000/0, pending=0, no load_pulse. Also run 256 commits -> load_count wraps to 0.
